sbqm_param: RTL
===============

SBQM_PARAM -- requirements
Module: sbqm_param

Interface
REQ-001 Parameter DEPTH, default 7: maximum persons in queue, range 1..255.
REQ-002 Parameter TW, default 2: width of the teller-count input.
REQ-003 Parameter ST, default 3: service time per customer, in time units.
REQ-004 Parameter WW, default 5: width of the wait-time output.
REQ-005 Derived constant PW = clog2(DEPTH+1): person-count width.
REQ-006 clk  in  1: single clock; all state changes on the rising edge.
REQ-007 Resetn  in  1: asynchronous, active-low reset.
REQ-008 up_count  in  1: back beam, active-low; a falling edge is one arrival.
REQ-009 down_count  in  1: front beam, active-low; a falling edge is one departure.
REQ-010 tcount  in  TW: number of open tellers, sampled every cycle.
REQ-011 clear_err  in  1: synchronous clear of the sticky error flags.
REQ-012 pcount  out  PW: current number of persons in queue.
REQ-013 wcount  out  WW: estimated wait time, saturating.
REQ-014 empty_flag  out  1: high when pcount == 0.
REQ-015 full_flag  out  1: high when pcount == DEPTH.
REQ-016 closed_flag  out  1: high when the registered tcount == 0.
REQ-017 ovf_err / unf_err  out  1 each: sticky arrival-when-full / departure-when-empty flags.

Function
REQ-018 Each beam SHALL be registered once per cycle (prev_*); an event fires in the cycle where prev == 1 and input == 0.
REQ-019 A beam held low for any number of cycles SHALL produce exactly one event.
REQ-020 pcount SHALL update on the same rising edge that detects the event, giving 1-cycle latency from input sample to output.
REQ-021 Arrival only: pcount+1 if pcount < DEPTH; otherwise pcount holds and ovf_err is set.
REQ-022 Departure only: pcount-1 if pcount > 0; otherwise pcount holds and unf_err is set.
REQ-023 Arrival and departure in the same cycle: pcount unchanged and no error, including when the queue is full or empty.
REQ-024 pcount SHALL never wrap and never exceed DEPTH.
REQ-025 empty_flag and full_flag SHALL be decoded from registered pcount, so they change in the same cycle as pcount.
REQ-026 wcount SHALL be registered one cycle after pcount/tcount.
REQ-027 wcount = ST*(pcount+tcount-1)/tcount, using integer floor division, when pcount > 0 and tcount > 0.
REQ-028 wcount = 0 when pcount == 0.
REQ-029 When tcount == 0 and pcount > 0, wcount SHALL be all ones and closed_flag SHALL be 1.
REQ-030 If the wait result exceeds 2^WW-1, wcount SHALL saturate to 2^WW-1.
REQ-031 Wait arithmetic SHALL use width PW+TW+clog2(ST+1)+1, with no intermediate truncation.
REQ-032 clear_err SHALL clear both error flags on the next edge. If an error event occurs in the same cycle, the error takes priority and the flag stays 1.
REQ-033 Changing tcount SHALL alter wcount only; pcount is unaffected.

Reset
REQ-034 While Resetn == 0, outputs SHALL immediately take these values: pcount 0, wcount 0, empty_flag 1, full_flag 0, closed_flag 0, ovf_err 0, unf_err 0.
REQ-035 On reset, prev_up and prev_down SHALL be set to 1, so a beam already low at reset release is counted once.
REQ-036 A reset asserted mid-operation SHALL discard the queue state. No event is counted while Resetn == 0.

Verification
REQ-037 Basic count and wait (DEPTH=7, ST=3, tcount=1): 3 arrival pulses -> pcount 3, empty_flag 0, wcount 9 one cycle after pcount settles.
REQ-038 Multi-teller wait: tcount=2 with pcount 3 -> wcount 6; tcount=3 with pcount 7 -> wcount 9, full_flag 1.
REQ-039 Overflow and clear: 8 arrivals from empty -> pcount 7, full_flag 1, ovf_err 1. Then clear_err for one cycle -> ovf_err 0, pcount still 7.
REQ-040 Underflow and simultaneous events: departure when empty -> pcount 0, unf_err 1. Simultaneous up/down falling edges at pcount 4 -> pcount 4, no error.
REQ-041 Held beam and closed state: up_count held low for 5 cycles -> pcount +1 only. tcount=0 with pcount 2 -> wcount 31, closed_flag 1.
REQ-042 Asynchronous reset: Resetn pulled low between clock edges with pcount 5 -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/sbqm_param_if.sv
// sbqm_param_if: beam, teller and status signals of the queue monitor
interface sbqm_param_if #(
  parameter int DEPTH = 7,
  parameter int TW    = 2,
  parameter int WW    = 5
);
  localparam int PW = $clog2(DEPTH + 1);
  logic          up_count;
  logic          down_count;
  logic [TW-1:0] tcount;
  logic          clear_err;
  logic [PW-1:0] pcount;
  logic [WW-1:0] wcount;
  logic          empty_flag;
  logic          full_flag;
  logic          closed_flag;
  logic          ovf_err;
  logic          unf_err;
  modport master (
    output up_count, down_count, tcount, clear_err,
    input  pcount, wcount, empty_flag, full_flag, closed_flag, ovf_err, unf_err
  );
  modport slave (
    input  up_count, down_count, tcount, clear_err,
    output pcount, wcount, empty_flag, full_flag, closed_flag, ovf_err, unf_err
  );
endinterface

// File: rtl/sbqm_param.sv
// sbqm_param: queue person counter with beam edge detection and wait-time estimate
module sbqm_param #(
  parameter int DEPTH = 7,
  parameter int TW    = 2,
  parameter int ST    = 3,
  parameter int WW    = 5
) (
  input logic          clk,
  input logic          Resetn,
  sbqm_param_if.slave  bus
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = PW + TW + $clog2(ST + 1) + 1;
  localparam logic [63:0] WMAX = (64'd1 << WW) - 64'd1;
  logic          r_prev_up, r_prev_down, r_closed, r_ovf, r_unf;
  logic [PW-1:0] r_pcount;
  logic [TW-1:0] r_tcount;
  logic [WW-1:0] r_wcount;
  logic          w_arr, w_dep, w_full, w_empty;
  logic [AW-1:0] w_num, w_div, w_quo;
  logic [WW-1:0] w_wait;
  // beam falling edges, occupancy decode and saturating wait estimate
  always_comb begin
    w_arr   = r_prev_up & ~bus.up_count;
    w_dep   = r_prev_down & ~bus.down_count;
    w_full  = r_pcount == PW'(DEPTH);
    w_empty = r_pcount == '0;
    w_div   = (r_tcount == '0) ? AW'(1) : AW'(r_tcount);
    w_num   = AW'(ST) * (AW'(r_pcount) + AW'(r_tcount) - AW'(1));
    w_quo   = w_num / w_div;
    w_wait  = w_empty ? '0 : (r_tcount == '0 || 64'(w_quo) > WMAX) ? '1 : WW'(w_quo);
  end
  // queue state: count, sticky errors (error beats clear), sampled tellers, wait
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_prev_up   <= 1'b1;
      r_prev_down <= 1'b1;
      r_pcount    <= '0;
      r_tcount    <= '0;
      r_closed    <= 1'b0;
      r_wcount    <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_prev_up   <= bus.up_count;
      r_prev_down <= bus.down_count;
      r_tcount    <= bus.tcount;
      r_closed    <= bus.tcount == '0;
      r_pcount    <= (w_arr & ~w_dep & ~w_full)  ? r_pcount + PW'(1) :
                     (w_dep & ~w_arr & ~w_empty) ? r_pcount - PW'(1) : r_pcount;
      r_ovf       <= (w_arr & ~w_dep & w_full)  | (r_ovf & ~bus.clear_err);
      r_unf       <= (w_dep & ~w_arr & w_empty) | (r_unf & ~bus.clear_err);
      r_wcount    <= w_wait;
    end
  end
  assign bus.pcount      = r_pcount;
  assign bus.wcount      = r_wcount;
  assign bus.empty_flag  = w_empty;
  assign bus.full_flag   = w_full;
  assign bus.closed_flag = r_closed;
  assign bus.ovf_err     = r_ovf;
  assign bus.unf_err     = r_unf;
endmodule
